// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Fetch gets a same-cycle predicted next PC from a direct-mapped table.
// The resolution stage reports the real outcome, gets a mispredict/redirect
// decision back, and the table plus two saturating statistics counters
// update on the following clock edge.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic [31:0]       lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_npc,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_npc,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  // Saturating up/down step of a direction counter.
  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c,
                                                   input logic                up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  // Saturating increment of a statistics counter; sticks at all-ones.
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [STAT_W-1:0]   branch_count_q, branch_count_d;
  logic [STAT_W-1:0]   mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                up_hit;
  logic [31:0]         actual_npc;

  logic                ent_we;
  logic [TAG_W-1:0]    ent_tag_d;
  logic [31:0]         ent_tgt_d;
  logic [CTR_BITS-1:0] ent_ctr_d;

  // The predicted direction travels with the predicted next PC, which is
  // what the mispredict decision actually compares against.
  logic                unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Zero-latency lookup against the registered table (no update bypass).
  always_comb begin
    pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_npc   = pred_taken ? tgt_q[lk_idx] : lookup_pc + 32'd4;
  end

  // Resolution: compare the carried prediction with the real next PC.
  always_comb begin
    actual_npc  = upd_taken ? upd_target : upd_pc + 32'd4;
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (upd_en) begin
      mispredict  = (upd_pred_npc != actual_npc);
      redirect_pc = actual_npc;
    end
  end

  // Next state of the single entry addressed by the resolving branch.
  // A not-taken miss leaves the table alone; a taken miss evicts whatever
  // alias occupies the slot.
  always_comb begin
    ent_we    = 1'b0;
    ent_tag_d = up_tag;
    ent_tgt_d = tgt_q[up_idx];
    ent_ctr_d = ctr_q[up_idx];
    if (upd_en) begin
      if (up_hit) begin
        ent_we    = 1'b1;
        ent_ctr_d = ctr_step(ctr_q[up_idx], upd_taken);
        if (upd_taken) ent_tgt_d = upd_target;
      end else if (upd_taken) begin
        ent_we    = 1'b1;
        ent_tgt_d = upd_target;
        ent_ctr_d = CTR_WEAK;
      end
    end
  end

  // Table storage; flush wins over a same-cycle entry write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (ent_we) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= ent_tag_d;
      tgt_q[up_idx]   <= ent_tgt_d;
      ctr_q[up_idx]   <= ent_ctr_d;
    end
  end

  // Statistics count every resolved update, flush or not.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_en) begin
      branch_count_d = stat_inc(branch_count_q);
      if (mispredict) mispredict_count_d = stat_inc(mispredict_count_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int STAT_W   = 8;
  localparam int STAT_W3  = 3;
  localparam int IDX_W    = $clog2(ENTRIES);

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_npc = '0;

  logic               pred_hit, pred_taken, mispredict;
  logic [31:0]        pred_npc, redirect_pc;
  logic [STAT_W-1:0]  branch_count, mispredict_count;

  logic               b_hit, b_taken, b_mis;
  logic [31:0]        b_npc, b_redir;
  logic [STAT_W3-1:0] b_bc, b_mc;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .STAT_W(STAT_W)) u_dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .STAT_W(STAT_W3)) u_dut_s3 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .lookup_pc(lookup_pc),
    .pred_hit(b_hit), .pred_taken(b_taken), .pred_npc(b_npc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
    .mispredict(b_mis), .redirect_pc(b_redir),
    .branch_count(b_bc), .mispredict_count(b_mc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  initial forever begin
    @(negedge nRST);
    model_reset();
  end

  // Compare process: check outputs mid-cycle, then advance the model by the
  // update that the next rising edge will commit.
  initial begin
    int          i;
    bit          e_hit, e_tk, e_mis, u_hit;
    logic [31:0] e_npc, e_act, e_red;
    model_reset();
    forever begin
      @(negedge CLK);
      if (!nRST) model_reset();
      i     = idx_of(lookup_pc);
      e_hit = m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
      e_tk  = e_hit && (m_ctr[i] >= (1 << (CTR_BITS - 1)));
      e_npc = e_tk ? m_tgt[i] : lookup_pc + 32'd4;
      e_act = upd_taken ? upd_target : upd_pc + 32'd4;
      e_mis = upd_en && (upd_pred_npc != e_act);
      e_red = upd_en ? e_act : 32'd0;
      chk("m_pred_hit", {31'd0, pred_hit}, {31'd0, e_hit});
      chk("m_pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
      chk("m_pred_npc", pred_npc, e_npc);
      chk("m_mispredict", {31'd0, mispredict}, {31'd0, e_mis});
      chk("m_redirect_pc", redirect_pc, e_red);
      chk("m_branch_count", 32'(branch_count), 32'(sat(m_bc, STAT_W)));
      chk("m_mispredict_count", 32'(mispredict_count), 32'(sat(m_mc, STAT_W)));
      chk("m_s3_branch_count", 32'(b_bc), 32'(sat(m_bc, STAT_W3)));
      chk("m_s3_mispredict_count", 32'(b_mc), 32'(sat(m_mc, STAT_W3)));
      if (nRST) begin
        if (flush) begin
          for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (upd_en) begin
          i     = idx_of(upd_pc);
          u_hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
          if (u_hit) begin
            if (upd_taken) begin
              m_tgt[i] = upd_target;
              m_ctr[i] = (m_ctr[i] + 1 > (1 << CTR_BITS) - 1) ? m_ctr[i] : m_ctr[i] + 1;
            end else begin
              m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
          end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = 1 << (CTR_BITS - 1);
          end
        end
        if (upd_en) begin
          if (m_bc < 1000000) m_bc++;
          if (e_mis && m_mc < 1000000) m_mc++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic en, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] pnpc);
    upd_en         = en;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_npc   = pnpc;
    upd_pred_taken = (pnpc != pc + 32'd4);
  endtask

  // n updates at 0x40 (target 0x100), each correctly predicted.
  task automatic hyst(input logic tk, input int n);
    for (int k = 0; k < n; k++) begin
      upd(1'b1, 32'h40, tk, 32'h100, tk ? 32'h100 : 32'h44);
      tick();
    end
    upd_en = 1'b0;
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'hFFFF_F000;
    return base + 32'(4 * $urandom_range(0, 47));
  endfunction

  initial begin
    #1 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Cold lookup and first allocation
    lookup_pc = 32'h40; #1;
    chk("cold_hit", {31'd0, pred_hit}, 32'd0);
    chk("cold_taken", {31'd0, pred_taken}, 32'd0);
    chk("cold_npc", pred_npc, 32'h44);
    chk("rst_branch_count", 32'(branch_count), 32'd0);
    chk("rst_mispredict_count", 32'(mispredict_count), 32'd0);
    chk("idle_mispredict", {31'd0, mispredict}, 32'd0);
    chk("idle_redirect", redirect_pc, 32'd0);
    upd(1'b1, 32'h40, 1'b1, 32'h100, 32'h44); #1;
    chk("cold_mispredict", {31'd0, mispredict}, 32'd1);
    chk("cold_redirect", redirect_pc, 32'h100);
    chk("same_cycle_hit", {31'd0, pred_hit}, 32'd0);
    tick();
    upd_en = 1'b0; #1;
    chk("next_cycle_hit", {31'd0, pred_hit}, 32'd1);
    chk("next_cycle_npc", pred_npc, 32'h100);
    chk("cold_branch_count", 32'(branch_count), 32'd1);
    chk("cold_mispredict_count", 32'(mispredict_count), 32'd1);

    // Hysteresis: 2 -> 0 (floor held), up to 3 (ceiling held), back down
    hyst(1'b0, 3); #1;
    chk("hyst_low_hit", {31'd0, pred_hit}, 32'd1);
    chk("hyst_low_npc", pred_npc, 32'h44);
    hyst(1'b1, 1); #1;
    chk("hyst_ctr1_taken", {31'd0, pred_taken}, 32'd0);
    hyst(1'b1, 1); #1;
    chk("hyst_ctr2_taken", {31'd0, pred_taken}, 32'd1);
    chk("hyst_ctr2_npc", pred_npc, 32'h100);
    hyst(1'b1, 4);
    hyst(1'b0, 1); #1;
    chk("hyst_sat_hi_taken", {31'd0, pred_taken}, 32'd1);
    hyst(1'b0, 1); #1;
    chk("hyst_ctr1_again", {31'd0, pred_taken}, 32'd0);
    chk("hyst_branch_count", 32'(branch_count), 32'd12);
    chk("hyst_mispredict_count", 32'(mispredict_count), 32'd1);
    chk("s3_branch_count_sat", 32'(b_bc), 32'd7);

    // Aliasing at index 0
    upd(1'b1, 32'h80, 1'b1, 32'h200, 32'h84); #1;
    chk("alias_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    upd_en = 1'b0; lookup_pc = 32'h40; #1;
    chk("alias_old_hit", {31'd0, pred_hit}, 32'd0);
    chk("alias_old_npc", pred_npc, 32'h44);
    lookup_pc = 32'h80; #1;
    chk("alias_new_hit", {31'd0, pred_hit}, 32'd1);
    chk("alias_new_npc", pred_npc, 32'h200);

    // Not-taken miss leaves the table alone
    upd(1'b1, 32'hC4, 1'b0, 32'h900, 32'hC8);
    tick();
    upd_en = 1'b0; lookup_pc = 32'hC4; #1;
    chk("nt_miss_no_alloc", {31'd0, pred_hit}, 32'd0);

    // Flush with a same-cycle allocating update
    lookup_pc = 32'h80; flush = 1'b1;
    upd(1'b1, 32'h48, 1'b1, 32'h300, 32'h300); #1;
    chk("flush_cycle_old_hit", {31'd0, pred_hit}, 32'd1);
    tick();
    flush = 1'b0; upd_en = 1'b0; #1;
    chk("post_flush_hit_80", {31'd0, pred_hit}, 32'd0);
    lookup_pc = 32'h48; #1;
    chk("post_flush_hit_48", {31'd0, pred_hit}, 32'd0);
    chk("flush_branch_count", 32'(branch_count), 32'd15);
    chk("flush_mispredict_count", 32'(mispredict_count), 32'd2);

    // Repopulate, then asynchronous reset with an update pending
    upd(1'b1, 32'h80, 1'b1, 32'h200, 32'h200);
    tick();
    upd_en = 1'b0; lookup_pc = 32'h80; #1;
    chk("repop_hit", {31'd0, pred_hit}, 32'd1);
    upd(1'b1, 32'h80, 1'b1, 32'h500, 32'h84);
    nRST = 1'b0; #1;
    chk("async_rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("async_rst_npc", pred_npc, 32'h84);
    chk("async_rst_branch_count", 32'(branch_count), 32'd0);
    chk("async_rst_mispredict_count", 32'(mispredict_count), 32'd0);
    chk("async_rst_s3_bc", 32'(b_bc), 32'd0);
    tick();
    upd_en = 1'b0; nRST = 1'b1; #1;
    chk("rst_drops_pending", {31'd0, pred_hit}, 32'd0);

    // Nine mispredicting updates: 3-bit counters stick at 7
    for (int k = 0; k < 9; k++) begin
      upd(1'b1, 32'h40, 1'b0, 32'h0, 32'h4C);
      tick();
    end
    upd_en = 1'b0; #1;
    chk("s3_bc_sat", 32'(b_bc), 32'd7);
    chk("s3_mc_sat", 32'(b_mc), 32'd7);
    chk("sat_phase_bc", 32'(branch_count), 32'd9);
    chk("sat_phase_mc", 32'(mispredict_count), 32'd9);

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] p, t;
      lookup_pc = pool_pc();
      p = ($urandom_range(0, 9) < 3) ? lookup_pc : pool_pc();
      t = 32'h2000 + 32'(4 * $urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       upd($urandom_range(0, 9) < 6, p, 1'($urandom_range(0, 1)), t, p + 32'd4);
        1:       upd($urandom_range(0, 9) < 6, p, 1'($urandom_range(0, 1)), t, t);
        default: upd($urandom_range(0, 9) < 6, p, 1'($urandom_range(0, 1)), t, pool_pc());
      endcase
      flush = ($urandom_range(0, 49) == 0);
      if (c == 1500) nRST = 1'b0;
      if (c == 1503) nRST = 1'b1;
      tick();
    end
    upd_en = 1'b0;
    flush  = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised branch target buffer with per-entry saturating direction counters. Replaces static not-taken fetch in the pipelined datapath. IF stage gets a same-cycle predicted next PC. The branch resolution stage writes back the actual outcome, gets a mispredict/redirect decision, and the block keeps saturating statistics counters.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 2..256
CTR_BITS, 2, direction counter width; 1..4
STAT_W, 32, width of statistics counters

Ports:
CLK  in  1  clock
nRST  in  1  reset; asynchronous, active-low
flush  in  1  synchronous clear of all entry valid bits
lookup_pc  in  32  PC being fetched
pred_hit  out  1  valid entry with matching tag at lookup_pc
pred_taken  out  1  predicted taken
pred_npc  out  32  predicted next PC
upd_en  in  1  a branch/jump resolves this cycle
upd_pc  in  32  PC of resolving instruction
upd_taken  in  1  actual direction
upd_target  in  32  actual target when taken
upd_pred_taken  in  1  pred_taken carried down the pipe for this instruction
upd_pred_npc  in  32  pred_npc carried down the pipe for this instruction
mispredict  out  1  flush younger stages and redirect fetch
redirect_pc  out  32  correct next PC
branch_count  out  STAT_W  resolved updates seen
mispredict_count  out  STAT_W  mispredicts seen

Behaviour:
- IDX_W = log2(ENTRIES).
- index = pc[IDX_W+1:2].
- tag = pc[31:IDX_W+2].
- pc[1:0] ignored.
- Entry state: valid, tag, target (32), ctr (CTR_BITS).
- Reset, asynchronous: all valid = 0, tags/targets/ctr = 0, both stat counters = 0.
- Lookup is purely combinational, zero latency:
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[idx] MSB.
  - pred_npc = pred_taken ? target[idx] : lookup_pc + 4.
- With no entry valid, all outputs reflect a miss: pred_hit = 0, pred_taken = 0, pred_npc = lookup_pc + 4.
- Resolution, combinational while upd_en = 1:
  - actual_npc = upd_taken ? upd_target : upd_pc + 4.
  - mispredict = (upd_pred_npc != actual_npc).
  - redirect_pc = actual_npc.
  - When upd_en = 0: mispredict = 0, redirect_pc = 0.
- Table update on posedge when upd_en:
  - Hit at upd_pc: target <= upd_taken ? upd_target : old target.
  - Hit, taken: ctr increments, saturating at 2^CTR_BITS - 1.
  - Hit, not taken: ctr decrements, saturating at 0.
  - Miss and upd_taken: allocate. valid <= 1, tag <= upd tag, target <= upd_target, ctr <= 2^(CTR_BITS-1) (weakly taken). Any aliased entry is overwritten.
  - Miss and not taken: no table change.
- Stats on posedge when upd_en:
  - branch_count +1.
  - mispredict_count +1 if mispredict.
  - Both saturate at all-ones; no wrap.
- Simultaneous lookup and update to the same index: lookup sees pre-update state. No bypass. The new state is visible the next cycle.
- flush:
  - Clears all valid bits at posedge. ctr/target contents are don't-care.
  - flush takes priority over a same-cycle upd_en table write.
  - Stats still count that update.
  - Lookup during the flush cycle uses old state.
- Reset mid-operation: immediate return to reset values. No pending update is retained.
- The block never stalls. Callers hold lookup_pc stable across ihit stalls. Callers assert upd_en exactly once per resolved instruction.

Test Plan:
- Cold: reset, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_npc=0x44. Update pc=0x40 taken target=0x100, upd_pred_npc=0x44 -> mispredict=1, redirect_pc=0x100. Next cycle, lookup 0x40 -> pred_npc=0x100, branch_count=1, mispredict_count=1.
- Hysteresis (CTR_BITS=2): allocate 0x40 (ctr=2). Two not-taken updates -> ctr=0, lookup gives pred_npc=0x44. One taken update -> ctr=1, still not-taken. Second taken update -> ctr=2, predicted taken. Four further taken updates -> ctr stays 3.
- Aliasing (ENTRIES=16): allocate 0x40 taken to 0x100. Update 0x80 (same index 0) taken to 0x200 -> entry replaced. Lookup 0x40 -> pred_hit=0. Lookup 0x80 -> pred_npc=0x200.
- Same-cycle: lookup 0x40 while updating 0x40 taken (cold) -> that cycle pred_hit=0. Following cycle pred_hit=1.
- Flush: populated entries. flush plus same-cycle allocating update -> next cycle all lookups miss, branch_count still increments.
- Stats saturation (STAT_W=3): 9 mispredicting updates -> both counters stay at 7. Async nRST low mid-sequence -> counters and valid bits go to 0 immediately.
